// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with 2 read ports, write-back port, SP/T side ports and pending scoreboard.
// Optional REGFILE_BYPASS_EN forwards same-cycle writes to the read side. Rev 1.0
`default_nettype none

module regfile_mp #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned IN_IDX  = 9,
  parameter int unsigned SP_IDX  = 10,
  parameter int unsigned T_IDX   = 11,
  parameter int unsigned SP_STEP = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             busy_a,
  output logic             busy_b,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [1:0]       sp_op,
  input  logic             t_we,
  input  logic [WIDTH-1:0] t_data,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  output logic [WIDTH-1:0] out_in,
  output logic [WIDTH-1:0] out_sp,
  output logic [WIDTH-1:0] out_t,
  output logic [DEPTH-1:0] pend_vec
);

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic [WIDTH-1:0] w_next [DEPTH];
  logic [WIDTH-1:0] w_src  [DEPTH];
  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_pend_nxt;
  logic             w_wr_ok;
  logic             w_iss_ok;
  logic             w_rda_ok;
  logic             w_rdb_ok;

  assign w_wr_ok  = wr_en  && (32'(wr_addr)   < DEPTH);
  assign w_iss_ok = iss_en && (32'(iss_addr)  < DEPTH);
  assign w_rda_ok = (32'(rd_addr_a) < DEPTH);
  assign w_rdb_ok = (32'(rd_addr_b) < DEPTH);

  // Main port is applied last so it overrides the SP/T side ports on a collision.
  always_comb begin
    w_next = r_regs;
    case (sp_op)
      2'b01:   w_next[SP_IDX] = r_regs[SP_IDX] + WIDTH'(SP_STEP);
      2'b10:   w_next[SP_IDX] = r_regs[SP_IDX] - WIDTH'(SP_STEP);
      default: ;
    endcase
    if (t_we)    w_next[T_IDX]   = t_data;
    if (w_wr_ok) w_next[wr_addr] = wr_data;
  end

  // Issue is applied after write-back clear: a new producer supersedes the retiring one.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr_ok)  w_pend_nxt[wr_addr]  = 1'b0;
    if (w_iss_ok) w_pend_nxt[iss_addr] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_regs <= '{default: '0};
      r_pend <= '0;
    end else begin
      r_regs <= w_next;
      r_pend <= w_pend_nxt;
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_comb w_src = w_next;
`else
  always_comb w_src = r_regs;
`endif

  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    busy_a    = 1'b0;
    busy_b    = 1'b0;
    if (RST && w_rda_ok) begin
      rd_data_a = w_src[rd_addr_a];
      busy_a    = r_pend[rd_addr_a];
`ifdef REGFILE_BYPASS_EN
      if (w_wr_ok && (wr_addr == rd_addr_a))
        busy_a = w_iss_ok && (iss_addr == rd_addr_a);
`endif
    end
    if (RST && w_rdb_ok) begin
      rd_data_b = w_src[rd_addr_b];
      busy_b    = r_pend[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
      if (w_wr_ok && (wr_addr == rd_addr_b))
        busy_b = w_iss_ok && (iss_addr == rd_addr_b);
`endif
    end
  end

  assign out_in   = RST ? w_src[IN_IDX] : '0;
  assign out_sp   = RST ? w_src[SP_IDX] : '0;
  assign out_t    = RST ? w_src[T_IDX]  : '0;
  assign pend_vec = RST ? r_pend        : '0;

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scoreboard bench for regfile_mp (DEPTH=12 to exercise out-of-range addresses).
`default_nettype none

module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int SEL_RDA = 0, SEL_RDB = 1, SEL_BSA = 2, SEL_BSB = 3;
  localparam int SEL_SP = 4, SEL_T = 5, SEL_PND = 6, SEL_IN = 7;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [3:0]  rd_addr_a = '0, rd_addr_b = '0, wr_addr = '0, iss_addr = '0;
  logic [15:0] rd_data_a, rd_data_b, wr_data = '0, t_data = '0;
  logic [15:0] out_in, out_sp, out_t;
  logic        busy_a, busy_b;
  logic        wr_en = 1'b0, t_we = 1'b0, iss_en = 1'b0;
  logic [1:0]  sp_op = 2'b00;
  logic [11:0] pend_vec;

  regfile_mp #(.WIDTH(16), .DEPTH(12), .AW(4), .IN_IDX(9), .SP_IDX(10), .T_IDX(11), .SP_STEP(1)) dut (
    .CLK(CLK), .RST(RST),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .busy_a(busy_a), .busy_b(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sp_op(sp_op), .t_we(t_we), .t_data(t_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .out_in(out_in), .out_sp(out_sp), .out_t(out_t),
    .pend_vec(pend_vec)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       nm;
  } item_t;

  item_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      SEL_RDA: return {16'h0, rd_data_a};
      SEL_RDB: return {16'h0, rd_data_b};
      SEL_BSA: return {31'h0, busy_a};
      SEL_BSB: return {31'h0, busy_b};
      SEL_SP:  return {16'h0, out_sp};
      SEL_T:   return {16'h0, out_t};
      SEL_PND: return {20'h0, pend_vec};
      default: return {16'h0, out_in};
    endcase
  endfunction

  task automatic chk(input int sel, input logic [31:0] exp, input string nm);
    q.push_back('{sel, exp, nm});
  endtask

  // Monitor: every expectation queued during the current cycle is checked at the falling edge.
  always @(negedge CLK) begin
    while (q.size() > 0) begin
      item_t it;
      logic [31:0] a;
      it = q.pop_front();
      a  = actual(it.sel);
      n_tests++;
      if (a !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", it.nm, a, it.exp);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
    wr_en = 1'b0; t_we = 1'b0; iss_en = 1'b0; sp_op = 2'b00;
  endtask

  initial begin
    // Reset state
    step();
    chk(SEL_RDA, 32'h0, "reset_rd_a");
    chk(SEL_PND, 32'h0, "reset_pend");
    chk(SEL_SP,  32'h0, "reset_sp");
    chk(SEL_T,   32'h0, "reset_t");

    step(); RST = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234; rd_addr_a = 4'd3;
    chk(SEL_RDA, BYP ? 32'h1234 : 32'h0, "wr_r3_same_cycle");

    step();
    chk(SEL_RDA, 32'h1234, "rd_r3");

    // Reset asserted mid-cycle with a write, SP, T and issue all in flight
    step(); RST = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h5555; sp_op = 2'b01;
    t_we = 1'b1; t_data = 16'h0007; iss_en = 1'b1; iss_addr = 4'd4; rd_addr_b = 4'd4;
    chk(SEL_RDA, 32'h0, "rst_mid_rd_a");
    chk(SEL_PND, 32'h0, "rst_mid_pend");
    chk(SEL_SP,  32'h0, "rst_mid_sp");
    chk(SEL_BSB, 32'h0, "rst_mid_busy_b");

    step(); RST = 1'b1;
    chk(SEL_RDA, 32'h0, "post_rst_r3_discarded");
    chk(SEL_SP,  32'h0, "post_rst_sp");
    chk(SEL_T,   32'h0, "post_rst_t");
    chk(SEL_PND, 32'h0, "post_rst_pend");

    // Write / read both ports
    step();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF; rd_addr_a = 4'd5; rd_addr_b = 4'd5;
    chk(SEL_RDA, BYP ? 32'hBEEF : 32'h0, "wr_r5_a_same_cycle");
    chk(SEL_RDB, BYP ? 32'hBEEF : 32'h0, "wr_r5_b_same_cycle");

    step();
    chk(SEL_RDA, 32'hBEEF, "rd_r5_a");
    chk(SEL_RDB, 32'hBEEF, "rd_r5_b");

    // Out-of-range write (DEPTH=12)
    step();
    wr_en = 1'b1; wr_addr = 4'hF; wr_data = 16'h1111; rd_addr_a = 4'hF;
    chk(SEL_RDA, 32'h0, "oor_rd_same_cycle");

    step();
    chk(SEL_RDA, 32'h0, "oor_rd_after");
    chk(SEL_RDB, 32'hBEEF, "oor_r5_intact");
    chk(SEL_PND, 32'h0, "oor_pend");

    // SP wrap
    step(); sp_op = 2'b10;
    chk(SEL_SP, BYP ? 32'hFFFF : 32'h0, "sp_dec_same_cycle");

    step(); sp_op = 2'b01;
    chk(SEL_SP, BYP ? 32'h0 : 32'hFFFF, "sp_wrap_down");

    step();
    sp_op = 2'b01; wr_en = 1'b1; wr_addr = 4'd10; wr_data = 16'h4000;
    t_we = 1'b1; t_data = 16'h00C3;
    chk(SEL_SP, BYP ? 32'h4000 : 32'h0, "sp_wrap_up_main_wins");
    chk(SEL_T,  BYP ? 32'h00C3 : 32'h0, "t_concurrent");

    step(); rd_addr_a = 4'd10;
    chk(SEL_SP,  32'h4000, "sp_main_port_won");
    chk(SEL_T,   32'h00C3, "t_written");
    chk(SEL_RDA, 32'h4000, "rd_sp_reg");

    step();
    t_we = 1'b1; t_data = 16'h0001; wr_en = 1'b1; wr_addr = 4'd11; wr_data = 16'h2222;
    chk(SEL_T, BYP ? 32'h2222 : 32'h00C3, "t_collide_same_cycle");

    step();
    chk(SEL_T, 32'h2222, "t_main_port_won");

    // Scoreboard
    step(); iss_en = 1'b1; iss_addr = 4'd2; rd_addr_a = 4'd2;
    chk(SEL_BSA, 32'h0, "iss_r2_same_cycle");

    step();
    chk(SEL_BSA, 32'h1, "iss_r2_busy");
    chk(SEL_PND, 32'h004, "iss_r2_pend");

    step();
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h0077; iss_en = 1'b1; iss_addr = 4'd2;
    chk(SEL_BSA, 32'h1, "wr_iss_r2_busy_now");
    chk(SEL_RDA, BYP ? 32'h0077 : 32'h0, "wr_iss_r2_data_now");

    step();
    chk(SEL_BSA, 32'h1, "wr_iss_r2_still_pending");
    chk(SEL_PND, 32'h004, "wr_iss_r2_pend");
    chk(SEL_RDA, 32'h0077, "wr_iss_r2_data");

    step();
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h0088; iss_en = 1'b1; iss_addr = 4'hE;
    chk(SEL_BSA, BYP ? 32'h0 : 32'h1, "wr_r2_busy_now");

    step(); rd_addr_b = 4'hE;
    chk(SEL_BSA, 32'h0, "wr_r2_busy_cleared");
    chk(SEL_PND, 32'h0, "wr_r2_oor_iss_ignored");
    chk(SEL_RDA, 32'h0088, "wr_r2_data");
    chk(SEL_BSB, 32'h0, "oor_busy_b");

    // Bypass visibility
    step(); rd_addr_a = 4'd7; wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h00AA;
    chk(SEL_RDA, BYP ? 32'h00AA : 32'h0, "bypass_r7_before_edge");

    step();
    chk(SEL_RDA, 32'h00AA, "r7_after_edge");
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h0909;

    step();
    chk(SEL_IN, 32'h0909, "out_in");

    // Drain the scoreboard with a bounded wait
    begin
      int guard = 0;
      while (q.size() > 0 && guard < 20) begin
        @(posedge CLK);
        guard++;
      end
      #1;
      if (q.size() > 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL drain: got %0d pending expected 0", q.size());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
